burst_feeder: RTL

- Upstream stage of the 4-byte burst accumulator.
- Buffers bytes arriving on a valid/ready write port in a small FIFO.
- Once a full burst is buffered, pulses go_out for one cycle, then presents exactly BURST_LEN bytes on d_out on consecutive cycles. This matches the accumulator's GO then SUM timing.
- Producer side is decoupled from burst timing.

---
 rtl/burst_pkg.sv | 15 +
 rtl/burst_fifo_mem.sv | 51 +++++
 rtl/burst_feeder.sv | 111 +++++++++++
 3 files changed

// File: rtl/burst_pkg.sv
// Shared types and constants for the burst feeder and accumulator.
// Sum width is common to both sides of the burst link.
package burst_pkg;

  localparam int BURST_LEN_DEF = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int SUM_W         = DATA_W_DEF + $clog2(BURST_LEN_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GO     = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/burst_fifo_mem.sv
// Burst feeder storage: circular buffer with pointers and occupancy.
// Caller must gate push with !full and pop with !empty.
module burst_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Contents need no reset; only occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/burst_feeder.sv
// Buffers producer bytes and replays them as GO + BURST_LEN beats.
// Optional sticky overflow flag: define BURST_FEEDER_OVF_EN.
module burst_feeder
  import burst_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid_in,
  input  logic [DATA_W-1:0]     wr_data_in,
  output logic                  wr_ready_out,
  output logic                  go_out,
  output logic [DATA_W-1:0]     d_out,
  output logic                  busy_out,
`ifdef BURST_FEEDER_OVF_EN
  output logic                  ovf_out,
`endif
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  feeder_state_t     state, state_nxt;
  logic [BW-1:0]     beat, beat_nxt;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign push = wr_valid_in && !full;
  assign pop  = (state == STREAM) && !empty;

  burst_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_data_in),
    .pop     (pop),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // GO is only entered with a full burst buffered, so STREAM never underruns.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    unique case (state)
      IDLE: begin
        if (count >= CW'(BURST_LEN)) state_nxt = GO;
      end
      GO: begin
        state_nxt = STREAM;
        beat_nxt  = BW'(BURST_LEN - 1);
      end
      STREAM: begin
        if (beat == '0) state_nxt = IDLE;
        else            beat_nxt  = beat - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    go_out   = 1'b0;
    busy_out = 1'b0;
    d_out    = '0;
    unique case (1'b1)
      (state == GO): begin
        go_out   = 1'b1;
        busy_out = 1'b1;
      end
      (state == STREAM): begin
        busy_out = 1'b1;
        d_out    = rd_data;
      end
      default: ;
    endcase
  end

  assign wr_ready_out = !full;
  assign count_out    = count;

`ifdef BURST_FEEDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ovf_out <= 1'b0;
    else if (wr_valid_in && full) ovf_out <= 1'b1;
  end
`endif

endmodule
